// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, column strobes, idle row level.
// Pure declarations with no timing; nothing here exerts backpressure.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_RST  = 4'b1110;
    localparam logic [3:0] COL_1    = 4'b1101;
    localparam logic [3:0] COL_2    = 4'b1011;
    localparam logic [3:0] COL_3    = 4'b0111;
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = COL_RST;
            2'd1:    s = COL_1;
            2'd2:    s = COL_2;
            default: s = COL_3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad-side and display-side signals of the scanner; master is the scanner, slave the surroundings.
// Wires only: no latency and no flow control.
interface keypad_scan_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;
    logic [3:0] hex3;
    logic [3:0] hex2;
    logic [3:0] hex1;
    logic [3:0] hex0;

    modport master (
        input  row,
        output col, key, key_valid, key_held, hex3, hex2, hex1, hex0
    );

    modport slave (
        output row,
        input  col, key, key_valid, key_held, hex3, hex2, hex1, hex0
    );
endinterface

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for a bus of independently changing async bits; reset value is a parameter.
// Latency 2 clocks; no backpressure.
module sync_2ff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: strobes columns, debounces over whole scan frames, pulses key_valid once per press.
// key_valid lands 2 clocks after the frame-ending tick; no backpressure, each pulse is one cycle.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int N  = 18,
    parameter int DB = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);
    localparam int CW = $clog2(DB + 1);

    logic [N-1:0]  q;
    logic          tick;
    logic [1:0]    cidx;
    logic [3:0]    col_q;
    logic [3:0]    rs;

    logic          samp_hit;
    logic [1:0]    samp_row;
    logic [3:0]    samp_code;
    logic          fhit;
    logic [3:0]    fcode;
    logic          nhit;
    logic [3:0]    ncode;

    logic          frame_done;
    logic          done_hit;
    logic [3:0]    done_code;

    kp_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand;
    logic          acc_en;
    logic [3:0]    acc_code;

    logic [3:0]    key_q;
    logic          key_valid_q;
    logic          key_held_q;
    logic [3:0]    hex3_q, hex2_q, hex1_q, hex0_q;

    sync_2ff #(.W(4), .RST_VAL(ROW_IDLE)) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (kp.row),
        .q     (rs)
    );

    assign tick = (q == {N{1'b1}});

    // Downward scan leaves the lowest active-low row index in samp_row.
    always_comb begin
        samp_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rs[r]) samp_row = 2'(r);
        end
    end

    assign samp_hit  = (rs != ROW_IDLE);
    assign samp_code = {samp_row, cidx};

    always_comb begin
        nhit  = fhit;
        ncode = fcode;
        if (samp_hit && (!fhit || (samp_code < fcode))) begin
            nhit  = 1'b1;
            ncode = samp_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q          <= '0;
            cidx       <= 2'd0;
            col_q      <= COL_RST;
            fhit       <= 1'b0;
            fcode      <= 4'd0;
            done_hit   <= 1'b0;
            done_code  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            q          <= q + 1'b1;
            frame_done <= 1'b0;
            if (tick) begin
                cidx  <= cidx + 2'd1;
                col_q <= col_strobe(cidx + 2'd1);
                if (cidx == 2'd3) begin
                    done_hit   <= nhit;
                    done_code  <= ncode;
                    frame_done <= 1'b1;
                    fhit       <= 1'b0;
                    fcode      <= 4'd0;
                end else begin
                    fhit  <= nhit;
                    fcode <= ncode;
                end
            end
        end
    end

    assign cnt_inc = (cnt == CW'(DB)) ? cnt : cnt + 1'b1;

    // Acceptance is decided here so the history shift has a single source.
    always_comb begin
        acc_en   = 1'b0;
        acc_code = cand;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    acc_en   = done_hit && (DB == 1);
                    acc_code = done_code;
                end
                DEBOUNCE: acc_en = done_hit && (done_code == cand) && (cnt_inc >= CW'(DB));
                default:  acc_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= 4'd0;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            hex3_q      <= 4'd0;
            hex2_q      <= 4'd0;
            hex1_q      <= 4'd0;
            hex0_q      <= 4'd0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_done) begin
                case (state)
                    IDLE: begin
                        if (done_hit) begin
                            cand  <= done_code;
                            cnt   <= CW'(1);
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (done_hit && (done_code == cand)) cnt <= cnt_inc;
                        else                                 state <= IDLE;
                    end
                    PRESSED: begin
                        if (!done_hit) begin
                            cnt <= CW'(1);
                            if (DB == 1) begin
                                state      <= IDLE;
                                key_held_q <= 1'b0;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (done_hit) begin
                            state <= PRESSED;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc >= CW'(DB)) begin
                                state      <= IDLE;
                                key_held_q <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (acc_en) begin
                    state       <= PRESSED;
                    key_q       <= acc_code;
                    key_valid_q <= 1'b1;
                    key_held_q  <= 1'b1;
                    hex3_q      <= hex2_q;
                    hex2_q      <= hex1_q;
                    hex1_q      <= hex0_q;
                    hex0_q      <= acc_code;
                end
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.hex3      = hex3_q;
    assign kp.hex2      = hex2_q;
    assign kp.hex1      = hex1_q;
    assign kp.hex0      = hex0_q;
endmodule
